// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment count display:
// conversion FSM states, digit-register sizing and the nibble-to-segment decoder.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int DIGIT_REG_W    = 4 * NUM_DIGITS_DEF;

    // Active-low segment patterns, bit 0 = CA ... bit 6 = CG.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/seg7_count_display_bin2bcd.sv
// Sequential double-dabble converter: start loads the binary value, then B
// add-3/shift steps run one per cycle; done marks the cycle of the final step.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int B      = 4,
    parameter int DIGITS = DIGIT_REG_W / 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [B-1:0]        bin,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(B + 1);

    logic [B-1:0]        sreg;
    logic [CW-1:0]       cnt;
    logic                active;
    logic [4*DIGITS-1:0] adj;

    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = active && (cnt == CW'(1));

    // NOTE: non-blocking assignments so every register in the block samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg   <= '0;
            cnt    <= '0;
            active <= 1'b0;
            bcd    <= '0;
        end else if (start) begin
            sreg   <= bin;
            cnt    <= CW'(B);
            active <= 1'b1;
            bcd    <= '0;
        end else if (active) begin
            bcd  <= {adj[4*DIGITS-2:0], sreg[B-1]};
            sreg <= sreg << 1;
            cnt  <= cnt - CW'(1);
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/seg7_count_display.sv
// Displays a B-bit counter value on a multiplexed common-anode 7-seg display,
// decimal (via double dabble) or hex, with leading-zero blanking.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int B           = 4,
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int DIGIT_TICKS = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [B-1:0]          value,
    input  logic                  hex_mode,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic                  busy
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int TW = $clog2(DIGIT_TICKS);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                state;
    logic [B-1:0]          src_q;
    logic                  mode_q;
    logic [DW-1:0]         digits;
    logic [DW-1:0]         bcd;
    logic                  conv_done;
    logic                  change;
    logic                  start;
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;
    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;

    assign change = (value != src_q) || (hex_mode != mode_q);
    assign start  = (state == IDLE) && change && !hex_mode;

    bin2bcd_seq #(
        .B      (B),
        .DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Changes arriving while busy are picked up again once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_q  <= '0;
            mode_q <= 1'b0;
            digits <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (change) begin
                        src_q  <= value;
                        mode_q <= hex_mode;
                        busy   <= 1'b1;
                        state  <= hex_mode ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (conv_done) state <= DONE;
                end
                DONE: begin
                    digits <= mode_q ? DW'(src_q) : bcd;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit k blanks when every nibble at or above k is zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (digits[4*k +: 4] == 4'd0);
            blank[k]   = upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
            AN   <= '1;
            SEG  <= SEG_BLANK;
            DP   <= 1'b1;
        end else begin
            if (tick == TW'(DIGIT_TICKS - 1)) begin
                tick <= '0;
                idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                tick <= tick + TW'(1);
            end
            AN  <= blank[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
            SEG <= blank[idx] ? SEG_BLANK : seg_decode(4'(digits >> {idx, 2'b00}));
            DP  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// Self-checking bench: a B=8 and a B=4 display driven with directed and random
// values, compared per scanned digit against an arithmetic reference model.
module tb_seg7_count_display;

    localparam int DT = 4;
    localparam int ND = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] v8;
    logic       h8;
    logic [3:0] v4;
    logic       h4;
    logic [7:0] an8, an4;
    logic [6:0] seg8, seg4;
    logic       dp8, dp4, busy8, busy4;

    int checks = 0;
    int errors = 0;
    int edge_n;

    seg7_count_display #(.B(8), .NUM_DIGITS(ND), .DIGIT_TICKS(DT)) dut8 (
        .clk(clk), .reset(reset), .value(v8), .hex_mode(h8),
        .AN(an8), .SEG(seg8), .DP(dp8), .busy(busy8)
    );

    seg7_count_display #(.B(4), .NUM_DIGITS(ND), .DIGIT_TICKS(DT)) dut4 (
        .clk(clk), .reset(reset), .value(v4), .hex_mode(h4),
        .AN(an4), .SEG(seg4), .DP(dp4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the model derives the selected digit from it.
    always @(posedge clk) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int n);
        case (n)
            0:  return 7'b1000000;  1:  return 7'b1111001;
            2:  return 7'b0100100;  3:  return 7'b0110000;
            4:  return 7'b0011001;  5:  return 7'b0010010;
            6:  return 7'b0000010;  7:  return 7'b1111000;
            8:  return 7'b0000000;  9:  return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected {AN, SEG} while digit k is selected, showing number v in base 10 or 16.
    function automatic logic [14:0] exp_disp(input int unsigned v, input bit hex, input int k);
        int unsigned base = hex ? 16 : 10;
        int unsigned p = 1;
        logic [7:0] an;
        for (int i = 0; i < k; i++) p = p * base;
        if (k > 0 && (v / p) == 0) return {8'hFF, 7'h7F};
        an = ~(8'b1 << k);
        return {an, seg_ref(int'((v / p) % base))};
    endfunction

    function automatic logic [14:0] obs(input int inst);
        return (inst == 0) ? {an8, seg8} : {an4, seg4};
    endfunction

    function automatic logic bsy(input int inst);
        return (inst == 0) ? busy8 : busy4;
    endfunction

    task automatic scan_check(input int inst, input int unsigned v, input bit hex, input int cycles);
        int k;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            k = ((edge_n - 1) / DT) % ND;
            check($sformatf("scan%0d_v%0d_d%0d", inst, v, k), 32'(obs(inst)), 32'(exp_disp(v, hex, k)));
        end
    endtask

    // Counts busy-high cycles of the next conversion; 0 if none starts within a few cycles.
    task automatic measure_busy(input int inst, output int len);
        int w = 0;
        len = 0;
        @(negedge clk);
        while (!bsy(inst) && w < 4) begin
            @(negedge clk);
            w++;
        end
        while (bsy(inst) && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic convert8(input logic [7:0] nv, input logic nh, input int exp_len, input string tag);
        int len;
        v8 = nv;
        h8 = nh;
        measure_busy(0, len);
        check({tag, "_busy"}, 32'(len), 32'(exp_len));
        scan_check(0, nv, nh, ND * DT);
    endtask

    initial begin
        int len, rises;
        logic prev;
        logic [7:0] cur_v;
        logic cur_h;
        logic [7:0] nv;
        logic nh;
        logic [3:0] cur_v4;
        logic [3:0] nv4;

        reset = 1'b1;
        v8 = '0; h8 = 1'b0; v4 = '0; h4 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_an8",  32'(an8),   32'hFF);
            check("rst_seg8", 32'(seg8),  32'h7F);
            check("rst_busy", 32'(busy8), 32'h0);
            check("rst_an4",  32'(an4),   32'hFF);
        end
        reset = 1'b0;

        // Value 0 after release: digit 0 shows "0", rest blank; covers 7->0 wrap.
        scan_check(0, 0, 1'b0, ND * DT + DT);
        check("dp", 32'({dp8, dp4}), 32'h3);

        // B=4 decimal 9: busy B+1 = 5 cycles.
        v4 = 4'd9;
        measure_busy(1, len);
        check("b4_9_busy", 32'(len), 32'd5);
        scan_check(1, 9, 1'b0, ND * DT);
        cur_v4 = 4'd9;

        convert8(8'd255, 1'b0, 9, "dec255");
        convert8(8'hAF,  1'b1, 1, "hexAF");
        convert8(8'hAF,  1'b0, 9, "dec175");
        cur_v = 8'hAF;
        cur_h = 1'b0;

        for (int i = 0; i < 10; i++) begin
            nv = 8'($urandom_range(0, 255));
            nh = 1'($urandom_range(0, 1));
            if (i == 3) nv = cur_v;
            if (i == 3) nh = cur_h;
            convert8(nv, nh, (nv == cur_v && nh == cur_h) ? 0 : (nh ? 1 : 9), $sformatf("rnd%0d", i));
            cur_v = nv;
            cur_h = nh;
        end

        for (int i = 0; i < 4; i++) begin
            nv4 = 4'($urandom_range(0, 15));
            v4 = nv4;
            measure_busy(1, len);
            check($sformatf("b4rnd%0d_busy", i), 32'(len), (nv4 == cur_v4) ? 32'd0 : 32'd5);
            scan_check(1, nv4, 1'b0, ND * DT);
            cur_v4 = nv4;
        end

        // Value steps 3 -> 4 -> 5 while busy: exactly two conversions.
        convert8(8'd0, 1'b0, (cur_v == 8'd0 && !cur_h) ? 0 : 9, "zero");
        v8 = 8'd3;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) v8 = 8'd4;
            if (i == 1) v8 = 8'd5;
            if (busy8 && !prev) rises++;
            prev = busy8;
        end
        check("step_conversions", 32'(rises), 32'd2);
        scan_check(0, 5, 1'b0, ND * DT);

        // Reset during a conversion: display restarts from "0".
        v8 = 8'd200;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(an8), 32'hFF);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_zero", 32'(obs(0)), 32'(exp_disp(0, 1'b0, 0)));
        measure_busy(0, len);
        scan_check(0, 200, 1'b0, ND * DT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
